// File: rtl/hello_world_stim_seq.sv
// Stimulus sequencer for hello_world: walks {A,B} through 00,10,01,11 and captures F per vector.
// Optional STIM_CHECK_EN builds a sticky compare of each captured F against EXPECTED.
module hello_world_stim_seq #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [3:0]  EXPECTED    = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic [1:0] vec_idx,
  output logic [3:0] result,
  output logic       mismatch
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] Reload = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      result_q, result_d;
  logic            a_q, b_q, busy_q, done_q;
  logic            sample;
  logic            clear_run;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    result_d  = result_q;
    sample    = 1'b0;
    clear_run = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StDrive;
          idx_d     = 2'd0;
          cnt_d     = Reload;
          result_d  = 4'b0000;
          clear_run = 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          // Last held cycle: hello_world has settled on this vector.
          sample           = 1'b1;
          result_d[idx_q]  = f;
          cnt_d            = Reload;
          if (idx_q == 2'd3) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // a/b/busy/done are registered from the next state so they line up with vec_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      result_q <= 4'b0000;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      a_q      <= (state_d == StDrive) & idx_d[0];
      b_q      <= (state_d == StDrive) & idx_d[1];
      busy_q   <= (state_d == StDrive);
      done_q   <= (state_d == StDone);
    end
  end

`ifdef STIM_CHECK_EN
  logic mismatch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (clear_run) begin
      mismatch_q <= 1'b0;
    end else if (sample && (f != EXPECTED[idx_q])) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic       unused_sample;
  logic       unused_clear_run;
  logic [3:0] unused_expected;

  assign unused_sample    = sample;
  assign unused_clear_run = clear_run;
  assign unused_expected  = EXPECTED;
  assign mismatch         = 1'b0;
`endif

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = idx_q;
  assign result  = result_q;

endmodule

// File: tb/tb_hello_world_stim_seq.sv
// Directed bench for hello_world_stim_seq: H=10 and H=1 instances driving a modelled hello_world.
module tb_hello_world_stim_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start10, start1, or_mode, sel;
  logic a10, b10, busy10, done10, mis10, f10;
  logic a1, b1, busy1, done1, mis1, f1;
  logic [1:0] idx10, idx1;
  logic [3:0] res10, res1;

  // Stand-in for hello_world: F = A&B nominally, A|B to force a wrong response.
  assign f10 = or_mode ? (a10 | b10) : (a10 & b10);
  assign f1  = or_mode ? (a1 | b1) : (a1 & b1);

  hello_world_stim_seq #(.HOLD_CYCLES(10), .EXPECTED(4'b1000)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .a(a10), .b(b10), .f(f10), .busy(busy10),
    .done(done10), .vec_idx(idx10), .result(res10), .mismatch(mis10)
  );

  hello_world_stim_seq #(.HOLD_CYCLES(1), .EXPECTED(4'b1000)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .f(f1), .busy(busy1),
    .done(done1), .vec_idx(idx1), .result(res1), .mismatch(mis1)
  );

  logic       o_a, o_b, o_busy, o_done, o_mis;
  logic [1:0] o_idx;
  logic [3:0] o_res;
  assign o_a    = sel ? a1 : a10;
  assign o_b    = sel ? b1 : b10;
  assign o_busy = sel ? busy1 : busy10;
  assign o_done = sel ? done1 : done10;
  assign o_mis  = sel ? mis1 : mis10;
  assign o_idx  = sel ? idx1 : idx10;
  assign o_res  = sel ? res1 : res10;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start10 = v;
  endtask

  // Start seen at edge 0; iteration c samples cycle c (between edges c-1 and c).
  task automatic run_seq(input bit or_m, input bit poke);
    int h;
    int k;
    int dones;
    logic [3:0] er;
    logic ea, eb, eby, edn, em;
    h = sel ? 1 : 10;
    dones = 0;
    or_mode = or_m;
    set_start(1'b1);
    tick;
    set_start(1'b0);
    for (int c = 1; c <= 4 * h + 3; c++) begin
      eby = (c <= 4 * h);
      edn = (c == 4 * h + 1);
      k   = (c - 1) / h;
      ea  = eby & k[0];
      eb  = eby & k[1];
      er  = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        if (c >= (j + 1) * h + 1) er[j] = or_m ? (j != 0) : (j == 3);
      end
`ifdef STIM_CHECK_EN
      em = or_m && (c >= 2 * h + 1);
`else
      em = 1'b0;
`endif
      check($sformatf("h%0d or%0d c%0d {busy,done,a,b,result,mismatch}", h, or_m, c),
            {23'd0, o_busy, o_done, o_a, o_b, o_res, o_mis},
            {23'd0, eby, edn, ea, eb, er, em});
      if (eby) check($sformatf("h%0d c%0d vec_idx", h, c), {30'd0, o_idx}, {30'd0, k[1:0]});
      if (o_done) dones++;
      if (poke && c == 2) set_start(1'b1);
      if (poke && c == 3) set_start(1'b0);
      tick;
    end
    check($sformatf("h%0d or%0d done count", h, or_m), dones, 1);
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    start10 = 1'b0;
    start1 = 1'b0;
    or_mode = 1'b0;
    sel = 1'b0;
    tick;
    tick;
    check("reset h10", {22'd0, busy10, done10, a10, b10, idx10, res10, mis10}, 32'd0);
    check("reset h1", {22'd0, busy1, done1, a1, b1, idx1, res1, mis1}, 32'd0);
    rst = 1'b0;
    tick;

    run_seq(1'b0, 1'b0);
    run_seq(1'b1, 1'b0);

    // Reset while idle with nonzero result held.
    rst = 1'b1;
    tick;
    check("idle reset", {22'd0, busy10, done10, a10, b10, idx10, res10, mis10}, 32'd0);
    tick;
    rst = 1'b0;
    tick;
    check("after idle reset", {22'd0, busy10, done10, a10, b10, idx10, res10, mis10}, 32'd0);

    run_seq(1'b1, 1'b0);
    run_seq(1'b0, 1'b0);

    sel = 1'b1;
    run_seq(1'b0, 1'b0);
    run_seq(1'b1, 1'b1);

    // Mid-run reset on cycle 15 of an H=10 run.
    sel = 1'b0;
    or_mode = 1'b1;
    set_start(1'b1);
    tick;
    set_start(1'b0);
    for (int c = 1; c < 15; c++) tick;
    check("busy before mid-run reset", {31'd0, busy10}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid-run reset", {22'd0, busy10, done10, a10, b10, idx10, res10, mis10}, 32'd0);
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      if (done10 || busy10) dones++;
      tick;
    end
    check("no activity after mid-run reset", dones, 0);
    run_seq(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
